alu_cmp_stage: RTL

Registered output stage that sits directly downstream of the ALU adder/subtractor. It consumes the sum `s` and flags `z`/`v`/`n` plus a compare function code. It produces either the pass-through sum or a Beta-style compare result (CMPEQ/CMPLT/CMPLE) through a 2-entry valid/ready buffer. It also keeps a sticky overflow flag and a saturating overflow-event counter for debug and exception logic.

---
 rtl/alu_pkg.sv | 27 ++
 rtl/alu_cmp.sv | 25 ++
 rtl/alu_cmp_stage.sv | 117 +++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared encodings and payload types for the ALU compare/output stage.
package alu_pkg;

    localparam int unsigned DATA_W = 32;

    typedef enum logic [1:0] {
        CFN_PASS  = 2'b00,
        CFN_CMPEQ = 2'b01,
        CFN_CMPLT = 2'b10,
        CFN_CMPLE = 2'b11
    } cfn_e;

    typedef enum logic [1:0] {
        OCC_EMPTY = 2'b00,
        OCC_ONE   = 2'b01,
        OCC_FULL  = 2'b10
    } occ_e;

    // One buffered result: value plus the adder flags carried unmodified.
    typedef struct packed {
        logic [DATA_W-1:0] y;
        logic              z;
        logic              v;
        logic              n;
    } entry_t;

endpackage

// File: rtl/alu_cmp.sv
// Result selector: pass-through sum or Beta-style compare bit from the adder flags.
module alu_cmp
    import alu_pkg::*;
(
    input  logic [DATA_W-1:0] s,
    input  logic              z,
    input  logic              v,
    input  logic              n,
    input  logic [1:0]        cfn,
    output logic [DATA_W-1:0] y
);

    // Signed less-than is n^v after a subtract; less-or-equal adds the zero flag.
    always_comb begin
        y = '0;
        unique case (cfn_e'(cfn))
            CFN_PASS:  y = s;
            CFN_CMPEQ: y = DATA_W'(z);
            CFN_CMPLT: y = DATA_W'(n ^ v);
            CFN_CMPLE: y = DATA_W'(z | (n ^ v));
            default:   y = '0;
        endcase
    end

endmodule

// File: rtl/alu_cmp_stage.sv
// Registered ALU output stage: compare select, 2-entry valid/ready buffer, overflow tracking.
module alu_cmp_stage
    import alu_pkg::*;
#(
    parameter int unsigned CNT_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_s,
    input  logic              in_z,
    input  logic              in_v,
    input  logic              in_n,
    input  logic [1:0]        in_cfn,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_y,
    output logic              out_z,
    output logic              out_v,
    output logic              out_n,
    output logic              ovf_sticky,
    output logic [CNT_W-1:0]  ovf_cnt,
    input  logic              ovf_clr
);

    occ_e             state_q;
    occ_e             state_d;
    logic             rd_ptr_q;
    logic             wr_ptr_q;
    logic             out_valid_q;
    logic             in_ready_q;
    logic             ovf_sticky_q;
    logic [CNT_W-1:0] ovf_cnt_q;
    entry_t           mem_q [2];
    entry_t           entry_d;
    entry_t           head;
    logic [DATA_W-1:0] y_d;
    logic             push;
    logic             pop;
    logic             ovf_evt;

    alu_cmp u_cmp (
        .s   (in_s),
        .z   (in_z),
        .v   (in_v),
        .n   (in_n),
        .cfn (in_cfn),
        .y   (y_d)
    );

    assign push    = in_valid & in_ready_q;
    assign pop     = out_valid_q & out_ready;
    assign ovf_evt = push & (cfn_e'(in_cfn) == CFN_PASS) & in_v;
    assign entry_d = '{y: y_d, z: in_z, v: in_v, n: in_n};

    // Occupancy next-state; FULL never sees a push because in_ready is low there.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            OCC_EMPTY: if (push) state_d = OCC_ONE;
            OCC_ONE: begin
                if (push && !pop)      state_d = OCC_FULL;
                else if (pop && !push) state_d = OCC_EMPTY;
            end
            OCC_FULL:  if (pop) state_d = OCC_ONE;
            default:   state_d = OCC_EMPTY;
        endcase
    end

    // State, pointers and handshake flops; valid/ready registered from next occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= OCC_EMPTY;
            rd_ptr_q    <= 1'b0;
            wr_ptr_q    <= 1'b0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            state_q     <= state_d;
            out_valid_q <= (state_d != OCC_EMPTY);
            in_ready_q  <= (state_d != OCC_FULL);
            if (push) wr_ptr_q <= ~wr_ptr_q;
            if (pop)  rd_ptr_q <= ~rd_ptr_q;
        end
    end

    // Entry storage; contents are don't-care until written, outputs are masked.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= entry_d;
    end

    // Sticky overflow and saturating event count; an event in the clear cycle survives.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_sticky_q <= 1'b0;
            ovf_cnt_q    <= '0;
        end else if (ovf_clr) begin
            ovf_sticky_q <= ovf_evt;
            ovf_cnt_q    <= ovf_evt ? CNT_W'(1) : '0;
        end else if (ovf_evt) begin
            ovf_sticky_q <= 1'b1;
            if (ovf_cnt_q != {CNT_W{1'b1}}) ovf_cnt_q <= ovf_cnt_q + CNT_W'(1);
        end
    end

    assign head       = mem_q[rd_ptr_q];
    assign in_ready   = in_ready_q;
    assign out_valid  = out_valid_q;
    assign out_y      = out_valid_q ? head.y : '0;
    assign out_z      = out_valid_q & head.z;
    assign out_v      = out_valid_q & head.v;
    assign out_n      = out_valid_q & head.n;
    assign ovf_sticky = ovf_sticky_q;
    assign ovf_cnt    = ovf_cnt_q;

endmodule
